// File: rtl/vga_timing_if.sv
// Raster output bundle: pixel coordinates, blanking, sync and strobes.
// Driven by vga_timing_gen (master), consumed by the display path (slave).
interface vga_timing_if;
    logic [31:0] row;
    logic [31:0] col;
    logic        vnotactive;
    logic        blank;
    logic        hsync;
    logic        vsync;
    logic        pix_en;
    logic        frame_start;

    modport master (
        output row, col, vnotactive, blank, hsync, vsync, pix_en, frame_start
    );

    modport slave (
        input  row, col, vnotactive, blank, hsync, vsync, pix_en, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: row/col/vnotactive/frame_start registered, 0-cycle extra latency.
// hsync/vsync/blank trail row/col by SYNC_DELAY CLKs; no backpressure, output valid every cycle.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int CLK_DIV    = 2,
    parameter int SYNC_DELAY = 1
) (
    input  logic          CLK,
    input  logic          RST,
    vga_timing_if.master  vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [4:0] DIV_LAST  = 5'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [4:0] div;
    logic [9:0] hcount, vcount;
    logic [9:0] h_next, v_next;
    logic       px_adv, frame_wrap;
    logic       pix_en_q, frame_start_q, vna_q;
    logic       hs_raw, vs_raw, blank_raw;

    always_comb begin
        px_adv     = (div == DIV_LAST);
        h_next     = hcount;
        v_next     = vcount;
        frame_wrap = 1'b0;
        if (px_adv) begin
            if (hcount == H_LAST) begin
                h_next     = 10'd0;
                v_next     = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
                frame_wrap = (vcount == V_LAST);
            end else begin
                h_next = hcount + 10'd1;
            end
        end
    end

    // Raw sync/blank are registered from the next counter values so they
    // change on the same edge as row/col before entering the delay line.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div           <= 5'd0;
            hcount        <= 10'd0;
            vcount        <= 10'd0;
            pix_en_q      <= 1'b0;
            frame_start_q <= 1'b0;
            vna_q         <= 1'b0;
            hs_raw        <= 1'b1;
            vs_raw        <= 1'b1;
            blank_raw     <= 1'b0;
        end else begin
            div           <= px_adv ? 5'd0 : div + 5'd1;
            hcount        <= h_next;
            vcount        <= v_next;
            pix_en_q      <= px_adv;
            frame_start_q <= frame_wrap;
            vna_q         <= (v_next >= V_ACT);
            hs_raw        <= !((h_next >= HS_START) && (h_next < HS_END));
            vs_raw        <= !((v_next >= VS_START) && (v_next < VS_END));
            blank_raw     <= (h_next >= H_ACT) || (v_next >= V_ACT);
        end
    end

    assign vga.row         = {22'd0, vcount};
    assign vga.col         = {22'd0, hcount};
    assign vga.vnotactive  = vna_q;
    assign vga.pix_en      = pix_en_q;
    assign vga.frame_start = frame_start_q;

    generate
        if (SYNC_DELAY == 0) begin : g_nodly
            assign vga.hsync = hs_raw;
            assign vga.vsync = vs_raw;
            assign vga.blank = blank_raw;
        end else begin : g_dly
            // Stage bits: {hsync, vsync, blank}
            logic [2:0] dly [SYNC_DELAY];

            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    for (int i = 0; i < SYNC_DELAY; i++) dly[i] <= 3'b110;
                end else begin
                    dly[0] <= {hs_raw, vs_raw, blank_raw};
                    for (int i = 1; i < SYNC_DELAY; i++) dly[i] <= dly[i-1];
                end
            end

            assign vga.hsync = dly[SYNC_DELAY-1][2];
            assign vga.vsync = dly[SYNC_DELAY-1][1];
            assign vga.blank = dly[SYNC_DELAY-1][0];
        end
    endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three raster generators on a shrunken raster with random async reset pulses.
// Expected outputs come from a cycle-count model of the raster rules.
module tb_vga_timing_gen;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int NCYC = 4000;

    typedef struct packed {
        logic [31:0] row;
        logic [31:0] col;
        logic        vnotactive;
        logic        blank;
        logic        hsync;
        logic        vsync;
        logic        pix_en;
        logic        frame_start;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   k = 0;

    exp_t qa[$], qb[$], qc[$];

    vga_timing_if ia();
    vga_timing_if ib();
    vga_timing_if ic();

    vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .CLK_DIV(2), .SYNC_DELAY(1))
        dut_a (.CLK(CLK), .RST(RST), .vga(ia));
    vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .CLK_DIV(1), .SYNC_DELAY(0))
        dut_b (.CLK(CLK), .RST(RST), .vga(ib));
    vga_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .CLK_DIV(3), .SYNC_DELAY(3))
        dut_c (.CLK(CLK), .RST(RST), .vga(ic));

    always #5 CLK = ~CLK;

    // State after the k-th clock edge since reset release (k=0: in/just out of reset).
    function automatic exp_t model(input int kk, input int d, input int sd);
        exp_t e;
        int p, h, v, kd, h2, v2;
        p  = kk / d;
        h  = p % HT;
        v  = (p / HT) % VT;
        kd = (kk > sd) ? kk - sd : 0;
        h2 = (kd / d) % HT;
        v2 = ((kd / d) / HT) % VT;
        e.row         = 32'(v);
        e.col         = 32'(h);
        e.vnotactive  = (v >= VA);
        e.pix_en      = (kk > 0) && (kk % d == 0);
        e.frame_start = e.pix_en && (p % (HT * VT) == 0);
        e.hsync       = !((h2 >= HA + HF) && (h2 < HA + HF + HS));
        e.vsync       = !((v2 >= VA + VF) && (v2 < VA + VF + VS));
        e.blank       = (h2 >= HA) || (v2 >= VA);
        return e;
    endfunction

    task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s.%s t=%0t got %0d expected %0d", nm, fld, $time, act, exp);
        end
    endtask

    task automatic cmp_all(input string nm, input exp_t act, input exp_t exp);
        cmp(nm, "row",         act.row,                 exp.row);
        cmp(nm, "col",         act.col,                 exp.col);
        cmp(nm, "vnotactive",  32'(act.vnotactive),     32'(exp.vnotactive));
        cmp(nm, "blank",       32'(act.blank),          32'(exp.blank));
        cmp(nm, "hsync",       32'(act.hsync),          32'(exp.hsync));
        cmp(nm, "vsync",       32'(act.vsync),          32'(exp.vsync));
        cmp(nm, "pix_en",      32'(act.pix_en),         32'(exp.pix_en));
        cmp(nm, "frame_start", 32'(act.frame_start),    32'(exp.frame_start));
    endtask

    // Stimulus: drives RST just after each edge and queues the expected state.
    initial begin
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge CLK);
            if (RST) k++;
            #1;
            if (!RST) begin
                if (cyc >= 2 && $urandom_range(0, 2) == 0) RST = 1'b1;
            end else if (cyc > 1000 && (cyc == 1500 || $urandom_range(0, 399) == 0)) begin
                RST = 1'b0;
                k   = 0;
            end
            qa.push_back(model(k, 2, 1));
            qb.push_back(model(k, 1, 0));
            qc.push_back(model(k, 3, 3));
        end
        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Monitor: outputs are presented every cycle, sampled on the falling edge.
    always @(negedge CLK) begin
        if (qa.size() == 0 || qb.size() == 0 || qc.size() == 0) begin
            if ($time > 10) begin
                miscompares++;
                $display("FAIL queue underflow at t=%0t", $time);
            end
        end else begin
            cmp_all("A", exp_t'{ia.row, ia.col, ia.vnotactive, ia.blank, ia.hsync, ia.vsync, ia.pix_en, ia.frame_start}, qa.pop_front());
            cmp_all("B", exp_t'{ib.row, ib.col, ib.vnotactive, ib.blank, ib.hsync, ib.vsync, ib.pix_en, ib.frame_start}, qb.pop_front());
            cmp_all("C", exp_t'{ic.row, ic.col, ic.vnotactive, ic.blank, ic.hsync, ic.vsync, ic.pix_en, ic.frame_start}, qc.pop_front());
        end
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator that produces the pixel coordinate stream (row, col) and blanking/sync signals consumed by the tic-tac-toe `display` block. It divides CLK down to the pixel rate, walks a 640x480@60 Hz raster, and outputs VGA hsync/vsync. The sync outputs are delay-matched to the display's one-cycle registered RGB path, so monitor-side timing stays aligned.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, CLK cycles per pixel (legal range 1..16)
- SYNC_DELAY, 1, CLK cycles of delay on hsync/vsync/blank (legal range 0..4)
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- row  out  32  current line index, zero-extended from 10-bit vcount
- col  out  32  current pixel index, zero-extended from 10-bit hcount
- vnotactive  out  1  1 while vcount >= V_ACTIVE (vertical blanking; game-logic update window)
- blank  out  1  1 while outside the active area (hcount >= H_ACTIVE or vcount >= V_ACTIVE), delayed by SYNC_DELAY
- hsync  out  1  horizontal sync, active-low, delayed by SYNC_DELAY
- vsync  out  1  vertical sync, active-low, delayed by SYNC_DELAY
- pix_en  out  1  one-CLK strobe, high in the first CLK of each new pixel
- frame_start  out  1  one-CLK pulse when the counters wrap to (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Divider `div` counts 0..CLK_DIV-1. On the CLK edge where div == CLK_DIV-1: div <= 0, pixel advances, pix_en <= 1. Otherwise div <= div+1, pix_en <= 0. With CLK_DIV=1, pix_en stays high from the first edge after reset.
- Pixel advance: hcount <= hcount+1; at hcount == H_TOTAL-1, hcount <= 0 and vcount advances. vcount wraps from V_TOTAL-1 to 0.
- frame_start <= 1 on the advance that moves (H_TOTAL-1, V_TOTAL-1) to (0,0); 0 in all other cycles.
- Raw sync (undelayed): hsync_n = 0 iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751). vsync_n = 0 iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491).
- Raw blank is computed from the same counter values as row/col.
- hsync, vsync, and blank pass through a SYNC_DELAY-stage CLK-rate shift register. With SYNC_DELAY=0 they are driven from the same registers as row/col.
- row, col, vnotactive, and frame_start are not delayed; they describe the pixel the display is currently computing.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Timing
- Reset (RST low, async):
  - div=0, hcount=0, vcount=0.
  - row=0, col=0, pix_en=0, frame_start=0, vnotactive=0.
  - hsync=1, vsync=1, blank=0; all delay stages are filled with hsync=1, vsync=1, blank=0.
- First pix_en after reset release: on the CLK_DIV-th rising edge. That same edge moves col to 1.
- col stays stable for exactly CLK_DIV CLK cycles per pixel. One line = H_TOTAL*CLK_DIV CLK cycles; one frame = H_TOTAL*V_TOTAL*CLK_DIV CLK cycles (default 840000).
- hsync/vsync/blank transitions occur exactly SYNC_DELAY CLK cycles after the row/col change that causes them.
- Line wrap and frame wrap in the same cycle: hcount=0, vcount=0, and frame_start=1 all take effect on one edge.
- vnotactive rises on the edge where vcount becomes V_ACTIVE (at hcount=0). It falls on the edge where vcount becomes 0.
- Reset asserted mid-frame: all state returns to reset values immediately. The raster restarts at (0,0) with no partial-line output. frame_start is not pulsed for the restart.

## Test plan
- Reset release, CLK_DIV=2: pix_en first high on edge 2, col=1 on that edge; pix_en pattern 0,1,0,1…; row stays 0 for 1600 CLKs.
- Full line, defaults: hsync low for exactly 192 CLKs, starting SYNC_DELAY=1 CLK after col becomes 656; blank high from col=640 (+1 CLK) through col=799.
- Full frame, defaults: frame_start pulses exactly once every 840000 CLKs; vsync low for 2 lines = 3200 CLKs starting at row 490; vnotactive high for 45 lines.
- CLK_DIV=1, SYNC_DELAY=0: pix_en constantly 1; hsync falls on the same edge col becomes 656; frame period 420000 CLKs.
- Reset pulse asserted at row=300, col=417: outputs return to reset values asynchronously (no clock edge needed); after release, the counters restart at (0,0) and the next frame_start follows after one full frame period.
- Wrap corner: at (799,524) the next advance yields row=0, col=0, frame_start=1, vnotactive=0 on the same edge.
